// File: rtl/wb_data_arbiter_n.sv
// rtl/wb_data_arbiter_n.sv - N-master to 1-slave Wishbone data arbiter
// Round-robin or fixed-priority grant, registered request capture, ack timeout.
module wb_data_arbiter_n #(
    parameter int NUM_CPU  = 4,
    parameter int DW       = 32,
    parameter int AW       = 16,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CPU-1:0]    cpu_cyc_i,
    input  logic [NUM_CPU-1:0]    cpu_we_i,
    input  logic [NUM_CPU*AW-1:0] cpu_adr_i,
    input  logic [NUM_CPU*DW-1:0] cpu_dat_i,
    output logic [DW-1:0]         cpu_dat_o,
    output logic [NUM_CPU-1:0]    cpu_ack_o,
    output logic [NUM_CPU-1:0]    cpu_err_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [AW-1:0]         wb_adr_o,
    output logic [DW-1:0]         wb_dat_o,
    input  logic [DW-1:0]         wb_dat_i,
    input  logic                  wb_ack_i,
    output logic [NUM_CPU-1:0]    grant_o,
    output logic                  busy_o
);

    localparam int GW = $clog2(NUM_CPU);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [NUM_CPU-1:0] grant_q, grant_d;
    logic [GW-1:0]      gidx_q, gidx_d;
    logic [GW-1:0]      last_q, last_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [AW-1:0]      adr_q, adr_d;
    logic [DW-1:0]      wdat_q, wdat_d;
    logic [DW-1:0]      rdat_q, rdat_d;
    logic [NUM_CPU-1:0] ack_q, ack_d;
    logic [NUM_CPU-1:0] err_q, err_d;

    logic               req_found;
    logic [GW-1:0]      req_win;

    // Position i of the scan: rotates from last_grant+1 in round-robin mode.
    function automatic logic [GW-1:0] scan_idx(input int i, input logic [GW-1:0] last);
        int idx;
        idx = (ARB_MODE != 0) ? i : (int'(last) + 1 + i) % NUM_CPU;
        return GW'(idx);
    endfunction

    always_comb begin
        req_found = 1'b0;
        req_win   = '0;
        for (int i = 0; i < NUM_CPU; i++) begin
            if (!req_found && cpu_cyc_i[scan_idx(i, last_q)]) begin
                req_found = 1'b1;
                req_win   = scan_idx(i, last_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        ack_d   = '0;
        err_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (req_found) begin
                    adr_d            = cpu_adr_i[int'(req_win)*AW +: AW];
                    wdat_d           = cpu_dat_i[int'(req_win)*DW +: DW];
                    we_d             = cpu_we_i[req_win];
                    grant_d          = '0;
                    grant_d[req_win] = 1'b1;
                    gidx_d           = req_win;
                    last_d           = req_win;
                    cnt_d            = '0;
                    cyc_d            = 1'b1;
                    state_d          = S_XFER;
                end
            end
            S_XFER: begin
                // Ack beats both timeout and abort when they coincide.
                if (wb_ack_i) begin
                    if (!we_q) begin
                        rdat_d = wb_dat_i;
                    end
                    ack_d[gidx_q] = 1'b1;
                    cyc_d         = 1'b0;
                    state_d       = S_DONE;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d[gidx_q] = 1'b1;
                    cyc_d         = 1'b0;
                    state_d       = S_DONE;
                end else if (!cpu_cyc_i[gidx_q]) begin
                    cyc_d   = 1'b0;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= GW'(NUM_CPU - 1);
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign cpu_dat_o = rdat_q;
    assign cpu_ack_o = ack_q;
    assign cpu_err_o = err_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = wdat_q;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_data_arbiter_n.sv
// tb/tb_wb_data_arbiter_n.sv - scoreboard bench for wb_data_arbiter_n
// Instance 0: round-robin, TIMEOUT=8. Instance 1: fixed priority, TIMEOUT=4.
module tb_wb_data_arbiter_n;

    typedef struct {
        logic [3:0]  grant;
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [31:0] dat;
        logic [15:0] adr;
        logic        we;
        logic [31:0] wdat;
        int          len;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  cyc[2], we[2], gnt[2], ack[2], err[2];
    logic [63:0] adr_f[2];
    logic [127:0] dat_f[2];
    logic [31:0] cdat[2], wdat_o[2], sdat[2], rdata[2];
    logic        wcyc[2], wstb[2], wwe[2], wack[2], busy[2], sack[2], late[2];
    logic [15:0] wadr[2];
    int          dly[2], scnt[2], len[2];
    exp_t        sbq[2][$];
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_slave
        assign sdat[g] = rdata[g] ^ {16'h0, wadr[g]};
        assign wack[g] = sack[g] | late[g];
    end

    wb_data_arbiter_n #(.NUM_CPU(4), .DW(32), .AW(16), .ARB_MODE(0), .TIMEOUT(8)) dut_rr (
        .clk(clk), .rst(rst),
        .cpu_cyc_i(cyc[0]), .cpu_we_i(we[0]), .cpu_adr_i(adr_f[0]), .cpu_dat_i(dat_f[0]),
        .cpu_dat_o(cdat[0]), .cpu_ack_o(ack[0]), .cpu_err_o(err[0]),
        .wb_cyc_o(wcyc[0]), .wb_stb_o(wstb[0]), .wb_we_o(wwe[0]), .wb_adr_o(wadr[0]),
        .wb_dat_o(wdat_o[0]), .wb_dat_i(sdat[0]), .wb_ack_i(wack[0]),
        .grant_o(gnt[0]), .busy_o(busy[0])
    );

    wb_data_arbiter_n #(.NUM_CPU(4), .DW(32), .AW(16), .ARB_MODE(1), .TIMEOUT(4)) dut_fp (
        .clk(clk), .rst(rst),
        .cpu_cyc_i(cyc[1]), .cpu_we_i(we[1]), .cpu_adr_i(adr_f[1]), .cpu_dat_i(dat_f[1]),
        .cpu_dat_o(cdat[1]), .cpu_ack_o(ack[1]), .cpu_err_o(err[1]),
        .wb_cyc_o(wcyc[1]), .wb_stb_o(wstb[1]), .wb_we_o(wwe[1]), .wb_adr_o(wadr[1]),
        .wb_dat_o(wdat_o[1]), .wb_dat_i(sdat[1]), .wb_ack_i(wack[1]),
        .grant_o(gnt[1]), .busy_o(busy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [3:0] g, input logic [3:0] a, input logic [3:0] e,
                        input logic [31:0] dat, input logic [15:0] adr, input logic w,
                        input logic [31:0] wd, input int l);
        exp_t x;
        x.grant = g; x.ack = a; x.err = e; x.dat = dat;
        x.adr = adr; x.we = w; x.wdat = wd; x.len = l;
        sbq[d].push_back(x);
    endtask

    task automatic set_master(input int d, input int i, input logic [15:0] a, input logic w,
                              input logic [31:0] wd);
        adr_f[d][i*16 +: 16] = a;
        dat_f[d][i*32 +: 32] = wd;
        we[d][i]             = w;
    endtask

    task automatic wait_pulse(input int d, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((ack[d] | err[d]) == 4'b0 && n < budget);
        if ((ack[d] | err[d]) == 4'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_pulse dut%0d act=none exp=ack_or_err", d);
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk($sformatf("%s_grant%0d", tag, d), 32'(gnt[d]), 32'h0);
        chk($sformatf("%s_wbcyc%0d", tag, d), 32'(wcyc[d]), 32'h0);
        chk($sformatf("%s_busy%0d", tag, d), 32'(busy[d]), 32'h0);
        chk($sformatf("%s_ack%0d", tag, d), 32'(ack[d]), 32'h0);
        chk($sformatf("%s_err%0d", tag, d), 32'(err[d]), 32'h0);
    endtask

    // Slave: acks dly negedges after it first sees cyc high; dly 0 never acks.
    initial begin
        for (int d = 0; d < 2; d++) begin
            scnt[d] = 0;
            sack[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (wcyc[d]) begin
                    scnt[d]++;
                    sack[d] = (dly[d] != 0 && scnt[d] == dly[d]);
                end else begin
                    scnt[d] = 0;
                    sack[d] = 1'b0;
                end
            end
        end
    end

    // Monitor: every ack/err pulse pops and checks one scoreboard entry.
    initial begin
        exp_t e;
        for (int d = 0; d < 2; d++) len[d] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (gnt[d] == 4'b0) len[d] = 0;
                else if (wcyc[d]) len[d]++;
                if ((ack[d] | err[d]) != 4'b0) begin
                    if (sbq[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse dut%0d act=ack %b err %b exp=none", d, ack[d], err[d]);
                    end else begin
                        e = sbq[d].pop_front();
                        chk($sformatf("sb_grant%0d", d), 32'(gnt[d]), 32'(e.grant));
                        chk($sformatf("sb_ack%0d", d), 32'(ack[d]), 32'(e.ack));
                        chk($sformatf("sb_err%0d", d), 32'(err[d]), 32'(e.err));
                        chk($sformatf("sb_rdat%0d", d), cdat[d], e.dat);
                        chk($sformatf("sb_adr%0d", d), 32'(wadr[d]), 32'(e.adr));
                        chk($sformatf("sb_we%0d", d), 32'(wwe[d]), 32'(e.we));
                        chk($sformatf("sb_wdat%0d", d), wdat_o[d], e.wdat);
                        chk($sformatf("sb_cyclen%0d", d), 32'(len[d]), 32'(e.len));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord[5] = '{0, 1, 2, 3, 0};
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = '0; we[d] = '0; adr_f[d] = '0; dat_f[d] = '0;
            rdata[d] = '0; late[d] = 1'b0; dly[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk_idle(d, "reset");
            chk($sformatf("reset_stb%0d", d), 32'(wstb[d]), 32'h0);
            chk($sformatf("reset_rdat%0d", d), cdat[d], 32'h0);
            chk($sformatf("reset_adr%0d", d), 32'(wadr[d]), 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Round-robin with all four masters requesting continuously.
        for (int i = 0; i < 4; i++) set_master(0, i, 16'h1000 + 16'(i), 1'b0, 32'h1111_1111 * (i + 1));
        rdata[0] = 32'hA5A5_0000;
        dly[0]   = 1;
        for (int k = 0; k < 5; k++)
            push(0, 4'(1 << ord[k]), 4'(1 << ord[k]), 4'b0, 32'hA5A5_1000 + ord[k],
                 16'h1000 + 16'(ord[k]), 1'b0, 32'h1111_1111 * (ord[k] + 1), 1);
        cyc[0] = 4'b1111;
        for (int k = 0; k < 5; k++) wait_pulse(0, 20);
        cyc[0] = 4'b0000;
        repeat (2) @(negedge clk);

        // Single read by master 2, slave acks two cycles after cyc.
        set_master(0, 2, 16'h0010, 1'b0, 32'h2222_0010);
        rdata[0] = 32'hDEAD_BEFF;
        dly[0]   = 2;
        push(0, 4'b0100, 4'b0100, 4'b0, 32'hDEAD_BEEF, 16'h0010, 1'b0, 32'h2222_0010, 2);
        cyc[0] = 4'b0100;
        wait_pulse(0, 20);
        cyc[0] = 4'b0000;
        @(negedge clk);
        chk_idle(0, "read_after");

        // Write by master 0 that the slave never acks: timeout after 8 cycles.
        set_master(0, 0, 16'h0040, 1'b1, 32'hCAFE_F00D);
        dly[0] = 0;
        push(0, 4'b0001, 4'b0000, 4'b0001, 32'hDEAD_BEEF, 16'h0040, 1'b1, 32'hCAFE_F00D, 8);
        cyc[0] = 4'b0001;
        wait_pulse(0, 30);
        cyc[0]  = 4'b0000;
        late[0] = 1'b1;
        repeat (2) @(negedge clk);
        late[0] = 1'b0;
        @(negedge clk);
        chk_idle(0, "late_ack");
        chk("late_ack_rdat0", cdat[0], 32'hDEAD_BEEF);

        // Master 2 aborts in XFER.
        set_master(0, 2, 16'h0020, 1'b0, 32'h0);
        cyc[0] = 4'b0100;
        repeat (3) @(negedge clk);
        chk("abort_inxfer_cyc", 32'(wcyc[0]), 32'h1);
        chk("abort_inxfer_grant", 32'(gnt[0]), 32'h4);
        chk("abort_inxfer_busy", 32'(busy[0]), 32'h1);
        cyc[0] = 4'b0000;
        @(negedge clk);
        chk_idle(0, "abort");
        @(negedge clk);
        chk_idle(0, "abort_hold");

        // Fixed priority: master 1 always beats master 3 until it stops asking.
        set_master(1, 1, 16'h0300, 1'b0, 32'h0);
        set_master(1, 3, 16'h0333, 1'b0, 32'h0);
        rdata[1] = 32'h5A5A_0000;
        dly[1]   = 1;
        for (int k = 0; k < 3; k++)
            push(1, 4'b0010, 4'b0010, 4'b0, 32'h5A5A_0300, 16'h0300, 1'b0, 32'h0, 1);
        push(1, 4'b1000, 4'b1000, 4'b0, 32'h5A5A_0333, 16'h0333, 1'b0, 32'h0, 1);
        cyc[1] = 4'b1010;
        for (int k = 0; k < 3; k++) wait_pulse(1, 20);
        cyc[1] = 4'b1000;
        wait_pulse(1, 20);
        cyc[1] = 4'b0000;
        repeat (2) @(negedge clk);

        // TIMEOUT=4: ack on the last XFER cycle wins, then a real timeout.
        set_master(1, 0, 16'h0050, 1'b0, 32'h0);
        dly[1] = 4;
        push(1, 4'b0001, 4'b0001, 4'b0, 32'h5A5A_0050, 16'h0050, 1'b0, 32'h0, 4);
        cyc[1] = 4'b0001;
        wait_pulse(1, 20);
        cyc[1] = 4'b0000;
        repeat (2) @(negedge clk);
        dly[1] = 0;
        push(1, 4'b0001, 4'b0000, 4'b0001, 32'h5A5A_0050, 16'h0050, 1'b0, 32'h0, 4);
        cyc[1] = 4'b0001;
        wait_pulse(1, 20);
        cyc[1] = 4'b0000;
        repeat (2) @(negedge clk);
        chk_idle(1, "fp_after");

        // Asynchronous reset in the middle of a transfer.
        set_master(0, 1, 16'h0011, 1'b0, 32'h0);
        cyc[0] = 4'b0010;
        repeat (2) @(negedge clk);
        chk("prereset_cyc", 32'(wcyc[0]), 32'h1);
        chk("prereset_grant", 32'(gnt[0]), 32'h2);
        #2 rst = 1'b0;
        #1;
        chk_idle(0, "async_rst");
        chk("async_rst_rdat", cdat[0], 32'h0);
        chk("async_rst_adr", 32'(wadr[0]), 32'h0);
        cyc[0] = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_master(0, i, 16'h2000 + 16'(i), 1'b0, 32'h0);
        rdata[0] = 32'h0;
        dly[0]   = 1;
        push(0, 4'b0001, 4'b0001, 4'b0, 32'h0000_2000, 16'h2000, 1'b0, 32'h0, 1);
        cyc[0] = 4'b1111;
        wait_pulse(0, 20);
        cyc[0] = 4'b0000;
        repeat (3) @(negedge clk);

        chk("sb_left0", 32'(sbq[0].size()), 32'h0);
        chk("sb_left1", 32'(sbq[1].size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_data_arbiter_n.md
Name: wb_data_arbiter_n

Overview:
- Parametrised N-master to 1-slave Wishbone data-bus arbiter; successor to the fixed 4-core data arbiter.
- Sits between NUM_CPU j1 cores and the shared wb_ram data port.
- Adds three features the fixed version lacks: selectable round-robin or fixed-priority arbitration, registered request capture, and a slave-ack timeout that returns an error to the requesting core.

Parameters:
NUM_CPU, 4, number of masters (2..8)
DW, 32, data width
AW, 16, address width
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
TIMEOUT, 255, cycles in XFER without ack before error; 0 disables timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
cpu_cyc_i  in  NUM_CPU  per-master request (cyc)
cpu_we_i  in  NUM_CPU  per-master write enable
cpu_adr_i  in  NUM_CPU*AW  flattened addresses, master i at [i*AW +: AW]
cpu_dat_i  in  NUM_CPU*DW  flattened write data
cpu_dat_o  out  DW  read data, broadcast to all masters
cpu_ack_o  out  NUM_CPU  one-cycle ack pulse to granted master
cpu_err_o  out  NUM_CPU  one-cycle timeout error pulse to granted master
wb_cyc_o  out  1  slave cyc
wb_stb_o  out  1  slave stb (equal to wb_cyc_o)
wb_we_o  out  1  slave write enable
wb_adr_o  out  AW  slave address
wb_dat_o  out  DW  slave write data
wb_dat_i  in  DW  slave read data
wb_ack_i  in  1  slave ack
grant_o  out  NUM_CPU  one-hot current grant, 0 when idle
busy_o  out  1  high in XFER or DONE

Behaviour:
- Reset (rst = 0, asynchronous):
  - All outputs 0.
  - FSM in IDLE.
  - last_grant = NUM_CPU-1, so round-robin starts at master 0.
  - Timeout counter 0.
- All outputs registered; no combinational path from inputs to outputs.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - If any cpu_cyc_i is set, select winner g.
  - ARB_MODE=0: first set bit scanning from last_grant+1, wrapping modulo NUM_CPU.
  - ARB_MODE=1: lowest set index.
  - At the edge: latch adr/dat/we of g into wb_*_o; set grant_o = 1<<g, wb_cyc_o = wb_stb_o = 1, last_grant = g, counter = 0; enter XFER.
  - No request: stay in IDLE.
- XFER:
  - wb_ack_i = 1: cpu_dat_o <= wb_dat_i (reads only; write leaves cpu_dat_o unchanged), cpu_ack_o[g] <= 1, wb_cyc_o/wb_stb_o <= 0; go to DONE.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: cpu_err_o[g] <= 1, wb_cyc_o <= 0; go to DONE.
  - Else if cpu_cyc_i[g] = 0 (master abort): wb_cyc_o <= 0, grant_o <= 0; go to IDLE with no ack or err.
  - Else counter++.
  - Ack and timeout on the same cycle: ack wins and no err is issued.
  - Ack and abort on the same cycle: ack wins.
- DONE (one cycle):
  - ack/err pulse visible; grant_o still shows g.
  - Next edge: clear ack/err/grant, return to IDLE. No new arbitration occurs in DONE.
- Master contract: drop or change cyc at the edge that samples ack or err. A cyc still high in IDLE is a new request.
- Latency:
  - Request sampled in IDLE at edge 0 gives wb_cyc_o = 1 at edge 1.
  - Slave ack sampled at edge k gives cpu_ack_o at edge k+1.
  - Minimum turnaround to the next grant: 3 cycles.
- wb_ack_i outside XFER is ignored; late acks after timeout or abort are dropped.
- Only the granted master's inputs are sampled, and only in IDLE. Changes to adr/dat during XFER are ignored.
- Starvation-free in ARB_MODE=0: a persistent requester waits at most NUM_CPU-1 transfers.
- Reset mid-XFER: wb_cyc_o drops immediately (asynchronous); no ack or err is issued.

Test Plan:
1. Single read: cpu_cyc_i=4'b0100, adr 0x0010, slave acks 2 cycles after cyc with 0xDEADBEEF -> wb_adr_o=0x0010, grant_o=4'b0100, cpu_ack_o[2] one cycle, cpu_dat_o=0xDEADBEEF.
2. Round-robin fairness: ARB_MODE=0, all 4 cyc held high, slave acks immediately, each master drops and re-raises after its ack -> grant order 0,1,2,3,0; no master granted twice before the others.
3. Fixed priority: ARB_MODE=1, masters 1 and 3 requesting continuously -> master 1 granted every time, master 3 never while master 1 requests.
4. Timeout: TIMEOUT=8, master 0 write, slave never acks -> wb_cyc_o high exactly 8 cycles, cpu_err_o[0] one-cycle pulse, cpu_ack_o stays 0; late ack then ignored.
5. Ack on the timeout cycle: TIMEOUT=4, ack on the 4th XFER cycle -> cpu_ack_o[g]=1, cpu_err_o=0.
6. Abort and reset: master 2 drops cyc in XFER -> IDLE next cycle with no ack. Separately, assert rst=0 mid-XFER -> all outputs 0 immediately, and first grant after release goes to master 0.
